dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 17 +
 rtl/dmem_responder_if.sv | 27 ++
 rtl/dmem_wbuf.sv | 69 ++++++
 rtl/dmem_responder.sv | 148 ++++++++++++++
 tb/tb_dmem_responder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: drain FSM states and the
// write-buffer entry layout ({index, data}, index in the upper ADDR_W bits).
package dmem_responder_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WRITING = 1'b1
  } drain_state_e;

  // Width of one buffer entry: ADDR_W index bits above DATA_W data bits.
  function automatic int entry_w(input int addr_w);
    return addr_w + DATA_W;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU load/store port bundle between the core (master) and the data-memory
// responder (slave).
interface dmem_responder_if
  import dmem_responder_pkg::*;
#(
  parameter int WB_DEPTH = 4
);
  logic                        MemRead;
  logic                        MemWrite;
  logic [31:0]                 Addr;
  logic [DATA_W-1:0]           WriteData;
  logic [DATA_W-1:0]           ReadData;
  logic                        Busy;
  logic                        Overflow;
  logic                        AlignErr;
  logic [$clog2(WB_DEPTH):0]   Pending;

  modport master (
    output MemRead, MemWrite, Addr, WriteData,
    input  ReadData, Busy, Overflow, AlignErr, Pending
  );

  modport slave (
    input  MemRead, MemWrite, Addr, WriteData,
    output ReadData, Busy, Overflow, AlignErr, Pending
  );
endinterface

// File: rtl/dmem_wbuf.sv
// Circular write buffer: FIFO of {index, data} entries with a youngest-match
// forwarding lookup for loads.
module dmem_wbuf
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        res,
  input  logic                        push,
  input  logic                        pop,
  input  logic [ADDR_W-1:0]           push_idx,
  input  logic [DATA_W-1:0]           push_data,
  input  logic [ADDR_W-1:0]           look_idx,
  output logic                        full,
  output logic [$clog2(DEPTH):0]      count,
  output logic [ADDR_W-1:0]           head_idx,
  output logic [DATA_W-1:0]           head_data,
  output logic                        hit,
  output logic [DATA_W-1:0]           hit_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = entry_w(ADDR_W);

  logic [ENT_W-1:0] ent_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;

  // Pointers wrap naturally at DEPTH (power of two); occupancy moves by push - pop.
  always_ff @(posedge clk) begin
    if (res) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) tail_r <= tail_r + PTR_W'(1'b1);
      if (pop)  head_r <= head_r + PTR_W'(1'b1);
      count_r <= count_r + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage; a push into a full buffer reuses the slot popped at the same edge.
  always_ff @(posedge clk) begin
    if (push) ent_r[tail_r] <= {push_idx, push_data};
  end

  // Scan oldest to youngest so the last valid match (the youngest) wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] slot_v;
      logic             match_v;
      slot_v   = head_r + PTR_W'(i);
      match_v  = (CNT_W'(i) < count_r) && (ent_r[slot_v][ENT_W-1 -: ADDR_W] == look_idx);
      hit      = hit | match_v;
      hit_data = match_v ? ent_r[slot_v][DATA_W-1:0] : hit_data;
    end
  end

  assign full      = (count_r == CNT_W'(DEPTH));
  assign count     = count_r;
  assign head_idx  = ent_r[head_r][ENT_W-1 -: ADDR_W];
  assign head_data = ent_r[head_r][DATA_W-1:0];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: posted stores go through a write buffer drained into
// a slow word array; loads are combinational with store forwarding.
// Optional build macro DMEM_ALIGN_CHECK_EN enables misalignment checking.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int WB_DEPTH = 4,
  parameter int WR_LAT   = 2
) (
  input  logic              clk,
  input  logic              res,
  dmem_responder_if.slave   bus
);
  localparam int PEND_W = $clog2(WB_DEPTH) + 1;
  localparam int CNT_W  = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WR_LAT - 1);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  drain_state_e      state_r, state_nx;
  logic [CNT_W-1:0]  cnt_r, cnt_nx;
  logic              ovf_r;
  logic              align_r;

  logic [ADDR_W-1:0] idx_s;
  logic              misalign_s;
  logic              wr_req_s;
  logic              rd_ok_s;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic [PEND_W-1:0] count_s;
  logic [ADDR_W-1:0] head_idx_s;
  logic [DATA_W-1:0] head_data_s;
  logic              hit_s;
  logic [DATA_W-1:0] hit_data_s;
  logic [DATA_W-1:0] rd_data_s;
  logic              unused_s;

  assign idx_s = bus.Addr[ADDR_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign_s = (bus.Addr[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  assign unused_s = ^{bus.Addr[31:ADDR_W+2], bus.Addr[1:0]};

  assign wr_req_s = bus.MemWrite & ~misalign_s;
  assign rd_ok_s  = bus.MemRead  & ~misalign_s;
  // A commit at this edge frees a slot, so a full buffer can still take the store.
  assign pop_s    = (state_r == WRITING) && (cnt_r == '0);
  assign push_s   = wr_req_s && (!full_s || pop_s);

  dmem_wbuf #(
    .ADDR_W (ADDR_W),
    .DEPTH  (WB_DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .res       (res),
    .push      (push_s),
    .pop       (pop_s),
    .push_idx  (idx_s),
    .push_data (bus.WriteData),
    .look_idx  (idx_s),
    .full      (full_s),
    .count     (count_s),
    .head_idx  (head_idx_s),
    .head_data (head_data_s),
    .hit       (hit_s),
    .hit_data  (hit_data_s)
  );

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (res) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
    end
  end

  // Drain FSM next state: wait WR_LAT cycles per entry, then commit the head.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    case (state_r)
      IDLE: begin
        if (count_s != '0) begin
          state_nx = WRITING;
          cnt_nx   = CNT_LOAD;
        end else begin
          state_nx = IDLE;
        end
      end
      WRITING: begin
        if (cnt_r != '0) begin
          cnt_nx = cnt_r - CNT_W'(1'b1);
        end else if ((count_s > PEND_W'(1'b1)) || push_s) begin
          cnt_nx = CNT_LOAD;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Array commit; a reset at the commit edge discards the in-flight write.
  always_ff @(posedge clk) begin
    if (pop_s && !res) mem_r[head_idx_s] <= head_data_s;
  end

  // Sticky error flags.
  always_ff @(posedge clk) begin
    if (res) begin
      ovf_r   <= 1'b0;
      align_r <= 1'b0;
    end else begin
      if (wr_req_s && full_s && !pop_s) ovf_r <= 1'b1;
      if ((bus.MemRead || bus.MemWrite) && misalign_s) align_r <= 1'b1;
    end
  end

  // Load path: youngest buffered store wins over the array; idle reads return zero.
  always_comb begin
    rd_data_s = '0;
    if (rd_ok_s) begin
      rd_data_s = hit_s ? hit_data_s : mem_r[idx_s];
    end else begin
      rd_data_s = '0;
    end
  end

  assign bus.ReadData = rd_data_s;
  assign bus.Busy     = full_s;
  assign bus.Overflow = ovf_r;
  assign bus.AlignErr = align_r;
  assign bus.Pending  = count_s;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (ADDR_W=8, WB_DEPTH=4, WR_LAT=2).
// One vector per clock cycle; expected values are the pre-edge outputs.
module tb_dmem_responder;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [2:0]  exp_pend;
    logic        exp_busy;
    logic        exp_ovf;
    logic        exp_aerr;
  } vec_t;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic [2:0]  pend;
    logic        busy;
    logic        ovf;
    logic        aerr;
  } exp_t;

  logic clk;
  logic res;
  int   n_vec;
  int   n_err;
  vec_t tbl[$];
  exp_t exp_q[$];

  dmem_responder_if #(.WB_DEPTH(4)) bus ();

  dmem_responder #(
    .ADDR_W   (8),
    .WB_DEPTH (4),
    .WR_LAT   (2)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] exp_rd,
                              input logic [2:0] pend, input logic busy, input logic ovf,
                              input logic aerr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.exp_rd = exp_rd;
    v.exp_pend = pend; v.exp_busy = busy; v.exp_ovf = ovf; v.exp_aerr = aerr;
    return v;
  endfunction

  // Drive one cycle after the falling edge, record the expectation, sample before the rising edge.
  task automatic apply(input logic r, input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    res           = r;
    bus.MemRead   = v.rd;
    bus.MemWrite  = v.wr;
    bus.Addr      = v.addr;
    bus.WriteData = v.wd;
    e.tag = tag; e.rd = v.exp_rd; e.pend = v.exp_pend;
    e.busy = v.exp_busy; e.ovf = v.exp_ovf; e.aerr = v.exp_aerr;
    exp_q.push_back(e);
    #2;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got nothing to compare", tag);
    end else begin
      e = exp_q.pop_front();
      if (bus.ReadData !== e.rd) begin
        n_err++;
        $display("FAIL %s ReadData: got %h expected %h", e.tag, bus.ReadData, e.rd);
      end
      if (bus.Pending !== e.pend) begin
        n_err++;
        $display("FAIL %s Pending: got %0d expected %0d", e.tag, bus.Pending, e.pend);
      end
      if (bus.Busy !== e.busy) begin
        n_err++;
        $display("FAIL %s Busy: got %b expected %b", e.tag, bus.Busy, e.busy);
      end
      if (bus.Overflow !== e.ovf) begin
        n_err++;
        $display("FAIL %s Overflow: got %b expected %b", e.tag, bus.Overflow, e.ovf);
      end
      if (bus.AlignErr !== e.aerr) begin
        n_err++;
        $display("FAIL %s AlignErr: got %b expected %b", e.tag, bus.AlignErr, e.aerr);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    res = 1'b1;
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    bus.Addr = 32'h0; bus.WriteData = 32'h0;

    //              rd    wr    addr      wdata         exp_rd        pend  busy  ovf   aerr
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,        32'h0,        3'd0, 1'b0, 1'b0, 1'b0)); // reset state
    tbl.push_back(mk(1'b0, 1'b1, 32'h10, 32'hDEAD0000, 32'h0,        3'd0, 1'b0, 1'b0, 1'b0)); // preload 0x10
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,        32'h0,        3'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,        32'h0,        3'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,        32'h0,        3'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 32'h10, 32'h0,        32'hDEAD0000, 3'd0, 1'b0, 1'b0, 1'b0)); // array read
    tbl.push_back(mk(1'b0, 1'b1, 32'h20, 32'h11111111, 32'h0,        3'd0, 1'b0, 1'b0, 1'b0)); // store 0x20
    tbl.push_back(mk(1'b1, 1'b0, 32'h20, 32'h0,        32'h11111111, 3'd1, 1'b0, 1'b0, 1'b0)); // forwarded
    tbl.push_back(mk(1'b1, 1'b0, 32'h20, 32'h0,        32'h11111111, 3'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,        32'h0,        3'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 32'h20, 32'h0,        32'h11111111, 3'd0, 1'b0, 1'b0, 1'b0)); // committed
    tbl.push_back(mk(1'b0, 1'b1, 32'h20, 32'hA,        32'h0,        3'd0, 1'b0, 1'b0, 1'b0)); // store A
    tbl.push_back(mk(1'b1, 1'b1, 32'h20, 32'hB,        32'hA,        3'd1, 1'b0, 1'b0, 1'b0)); // store B, read A
    tbl.push_back(mk(1'b1, 1'b0, 32'h20, 32'h0,        32'hB,        3'd2, 1'b0, 1'b0, 1'b0)); // youngest
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,        32'h0,        3'd2, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 32'h20, 32'h0,        32'hB,        3'd1, 1'b0, 1'b0, 1'b0)); // A in array, B fwd
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,        32'h0,        3'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 32'h20, 32'h0,        32'hB,        3'd0, 1'b0, 1'b0, 1'b0)); // B in array
    tbl.push_back(mk(1'b0, 1'b1, 32'h00, 32'h100,      32'h0,        3'd0, 1'b0, 1'b0, 1'b0)); // burst
    tbl.push_back(mk(1'b0, 1'b1, 32'h04, 32'h104,      32'h0,        3'd1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h08, 32'h108,      32'h0,        3'd2, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h0C, 32'h10C,      32'h0,        3'd3, 1'b0, 1'b0, 1'b0)); // pop+push
    tbl.push_back(mk(1'b0, 1'b1, 32'h18, 32'h118,      32'h0,        3'd3, 1'b0, 1'b0, 1'b0)); // fills
    tbl.push_back(mk(1'b0, 1'b1, 32'h1C, 32'h11C,      32'h0,        3'd4, 1'b1, 1'b0, 1'b0)); // full + pop
    tbl.push_back(mk(1'b1, 1'b1, 32'h10, 32'h110,      32'hDEAD0000, 3'd4, 1'b1, 1'b0, 1'b0)); // dropped
    tbl.push_back(mk(1'b1, 1'b0, 32'h10, 32'h0,        32'hDEAD0000, 3'd4, 1'b1, 1'b1, 1'b0)); // overflow
    tbl.push_back(mk(1'b1, 1'b0, 32'h1C, 32'h0,        32'h11C,      3'd3, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,        32'h0,        3'd3, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,        32'h0,        3'd2, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,        32'h0,        3'd2, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,        32'h0,        3'd1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,        32'h0,        3'd1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 32'h00, 32'h0,        32'h100,      3'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 32'h08, 32'h0,        32'h108,      3'd0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 32'h10, 32'h0,        32'hDEAD0000, 3'd0, 1'b0, 1'b1, 1'b0)); // never landed
    tbl.push_back(mk(1'b0, 1'b1, 32'h30, 32'h5,        32'h0,        3'd0, 1'b0, 1'b1, 1'b0)); // preload 0x30
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,        32'h0,        3'd1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,        32'h0,        3'd1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,        32'h0,        3'd1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 32'h30, 32'h9,        32'h5,        3'd0, 1'b0, 1'b1, 1'b0)); // same-cycle RW
    tbl.push_back(mk(1'b1, 1'b0, 32'h30, 32'h0,        32'h9,        3'd1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h00, 32'hAA0,      32'h0,        3'd1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h04, 32'hAA4,      32'h0,        3'd2, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'h08, 32'hAA8,      32'h0,        3'd2, 1'b0, 1'b1, 1'b0));

    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      apply(1'b0, tbl[i], $sformatf("v%0d", i + 1));
    end

    // Reset lands on the edge where the head store (0xAA0) would commit.
    apply(1'b1, mk(1'b0, 1'b0, 32'h00, 32'h0, 32'h0,   3'd3, 1'b0, 1'b1, 1'b0), "rst_mid");
    apply(1'b0, mk(1'b1, 1'b0, 32'h00, 32'h0, 32'h100, 3'd0, 1'b0, 1'b0, 1'b0), "rst_w0");
    apply(1'b0, mk(1'b1, 1'b0, 32'h04, 32'h0, 32'h104, 3'd0, 1'b0, 1'b0, 1'b0), "rst_w1");
    apply(1'b0, mk(1'b1, 1'b0, 32'h08, 32'h0, 32'h108, 3'd0, 1'b0, 1'b0, 1'b0), "rst_w2");
    apply(1'b0, mk(1'b0, 1'b0, 32'h00, 32'h0, 32'h0,   3'd0, 1'b0, 1'b0, 1'b0), "rst_idle0");
    apply(1'b0, mk(1'b0, 1'b0, 32'h00, 32'h0, 32'h0,   3'd0, 1'b0, 1'b0, 1'b0), "rst_idle1");
    apply(1'b0, mk(1'b1, 1'b0, 32'h00, 32'h0, 32'h100, 3'd0, 1'b0, 1'b0, 1'b0), "rst_w0_late");

`ifdef DMEM_ALIGN_CHECK_EN
    apply(1'b0, mk(1'b0, 1'b1, 32'h22, 32'h77, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0), "al_st");
    apply(1'b0, mk(1'b1, 1'b0, 32'h22, 32'h0,  32'h0, 3'd0, 1'b0, 1'b0, 1'b1), "al_ld");
    apply(1'b0, mk(1'b0, 1'b0, 32'h00, 32'h0,  32'h0, 3'd0, 1'b0, 1'b0, 1'b1), "al_idle0");
    apply(1'b0, mk(1'b0, 1'b0, 32'h00, 32'h0,  32'h0, 3'd0, 1'b0, 1'b0, 1'b1), "al_idle1");
    apply(1'b0, mk(1'b1, 1'b0, 32'h20, 32'h0,  32'hB, 3'd0, 1'b0, 1'b0, 1'b1), "al_arr");
`else
    apply(1'b0, mk(1'b0, 1'b1, 32'h22, 32'h77, 32'h0,  3'd0, 1'b0, 1'b0, 1'b0), "al_st");
    apply(1'b0, mk(1'b1, 1'b0, 32'h22, 32'h0,  32'h77, 3'd1, 1'b0, 1'b0, 1'b0), "al_ld");
    apply(1'b0, mk(1'b0, 1'b0, 32'h00, 32'h0,  32'h0,  3'd1, 1'b0, 1'b0, 1'b0), "al_idle0");
    apply(1'b0, mk(1'b0, 1'b0, 32'h00, 32'h0,  32'h0,  3'd1, 1'b0, 1'b0, 1'b0), "al_idle1");
    apply(1'b0, mk(1'b1, 1'b0, 32'h20, 32'h0,  32'h77, 3'd0, 1'b0, 1'b0, 1'b0), "al_arr");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
